// File: rtl/uart_tx_arbiter_if.sv
// Requester and transmitter handshake bundle for uart_tx_arbiter.
// The slave modport is the arbiter's view; master is the requester/transmitter side.
interface uart_tx_arbiter_if #(
  parameter int NUM_REQ = 4
);
  logic [NUM_REQ-1:0]   i_req_valid;
  logic [8*NUM_REQ-1:0] i_req_data;
  logic [NUM_REQ-1:0]   o_req_ready;
  logic [7:0]           o_tx_data;
  logic                 o_tx_start;
  logic                 i_tx_busy;
  logic [2:0]           o_grant_id;
  logic                 o_busy;
  logic                 o_timeout;

  modport slave (
    input  i_req_valid, i_req_data, i_tx_busy,
    output o_req_ready, o_tx_data, o_tx_start, o_grant_id, o_busy, o_timeout
  );

  modport master (
    output i_req_valid, i_req_data, i_tx_busy,
    input  o_req_ready, o_tx_data, o_tx_start, o_grant_id, o_busy, o_timeout
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin share of one byte-serial UART transmitter among NUM_REQ requesters,
// with start strobe, busy tracking, inter-frame gap and a per-phase watchdog.
module uart_tx_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int GAP_CYCLES     = 16,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic               i_clk,
  input  logic               i_reset,
  uart_tx_arbiter_if.slave   bus
);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] START     = 3'd1;
  localparam logic [2:0] WAIT_BUSY = 3'd2;
  localparam logic [2:0] WAIT_DONE = 3'd3;
  localparam logic [2:0] GAP       = 3'd4;

  localparam int WD_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam int GAP_W = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;

  localparam logic [WD_W-1:0]  WD_LAST     = WD_W'(TIMEOUT_CYCLES - 1);
  localparam logic [GAP_W-1:0] GAP_LAST    = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [2:0]       AFTER_FRAME = (GAP_CYCLES > 0) ? GAP : IDLE;
  localparam logic [2:0]       LAST_INIT   = 3'(NUM_REQ - 1);
  localparam logic [3:0]       NUM_REQ_W   = 4'(NUM_REQ);

  logic [2:0]       state_r;
  logic [2:0]       state_n_s;
  logic [WD_W-1:0]  wd_cnt_r;
  logic [WD_W-1:0]  wd_cnt_n_s;
  logic [GAP_W-1:0] gap_cnt_r;
  logic [GAP_W-1:0] gap_cnt_n_s;
  logic [2:0]       last_r;
  logic [7:0]       tx_data_r;
  logic             tx_start_r;
  logic [2:0]       grant_id_r;
  logic             busy_r;
  logic             timeout_r;

  logic [7:0]       valid_pad_s;
  logic [63:0]      data_pad_s;
  logic [7:0]       ready_pad_s;
  logic [3:0]       sum_s;
  logic [3:0]       idx_s;
  logic             hit_s;
  logic             found_s;
  logic [2:0]       win_s;
  logic             accept_s;
  logic             timeout_s;

  // Round-robin winner search starting just after the last granted requester.
  always_comb begin
    valid_pad_s = 8'(bus.i_req_valid);
    data_pad_s  = 64'(bus.i_req_data);
    found_s     = 1'b0;
    win_s       = 3'd0;
    sum_s       = 4'd0;
    idx_s       = 4'd0;
    hit_s       = 1'b0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      sum_s   = {1'b0, last_r} + 4'(i);
      idx_s   = (sum_s >= NUM_REQ_W) ? (sum_s - NUM_REQ_W) : sum_s;
      hit_s   = valid_pad_s[idx_s[2:0]] && !found_s;
      win_s   = hit_s ? idx_s[2:0] : win_s;
      found_s = found_s | hit_s;
    end
    accept_s    = (state_r == IDLE) && found_s;
    // Ready is gated by reset so it reads as zero while reset is asserted.
    ready_pad_s = (accept_s && !i_reset) ? (8'd1 << win_s) : 8'd0;
  end

  // Next-state, watchdog and gap counter logic.
  always_comb begin
    state_n_s   = state_r;
    wd_cnt_n_s  = wd_cnt_r;
    gap_cnt_n_s = gap_cnt_r;
    timeout_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          state_n_s = START;
        end else begin
          state_n_s = IDLE;
        end
      end
      START: begin
        wd_cnt_n_s = {WD_W{1'b0}};
        state_n_s  = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (bus.i_tx_busy) begin
          wd_cnt_n_s = {WD_W{1'b0}};
          state_n_s  = WAIT_DONE;
        end else if (wd_cnt_r == WD_LAST) begin
          timeout_s   = 1'b1;
          gap_cnt_n_s = {GAP_W{1'b0}};
          state_n_s   = AFTER_FRAME;
        end else begin
          wd_cnt_n_s = wd_cnt_r + 1'b1;
        end
      end
      WAIT_DONE: begin
        if (!bus.i_tx_busy) begin
          gap_cnt_n_s = {GAP_W{1'b0}};
          state_n_s   = AFTER_FRAME;
        end else if (wd_cnt_r == WD_LAST) begin
          timeout_s   = 1'b1;
          gap_cnt_n_s = {GAP_W{1'b0}};
          state_n_s   = AFTER_FRAME;
        end else begin
          wd_cnt_n_s = wd_cnt_r + 1'b1;
        end
      end
      GAP: begin
        if (gap_cnt_r == GAP_LAST) begin
          state_n_s = IDLE;
        end else begin
          gap_cnt_n_s = gap_cnt_r + 1'b1;
        end
      end
      default: begin
        state_n_s = IDLE;
      end
    endcase
  end

  // State and counter registers.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_r   <= IDLE;
      wd_cnt_r  <= {WD_W{1'b0}};
      gap_cnt_r <= {GAP_W{1'b0}};
    end else begin
      state_r   <= state_n_s;
      wd_cnt_r  <= wd_cnt_n_s;
      gap_cnt_r <= gap_cnt_n_s;
    end
  end

  // Registered outputs and the round-robin pointer, updated on acceptance.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      tx_data_r  <= 8'h00;
      last_r     <= LAST_INIT;
      grant_id_r <= 3'd0;
      tx_start_r <= 1'b0;
      busy_r     <= 1'b0;
      timeout_r  <= 1'b0;
    end else begin
      if (accept_s) begin
        tx_data_r  <= data_pad_s[{win_s, 3'b000} +: 8];
        last_r     <= win_s;
        grant_id_r <= win_s;
      end
      tx_start_r <= accept_s;
      busy_r     <= (state_n_s != IDLE);
      timeout_r  <= timeout_s;
    end
  end

  assign bus.o_req_ready = ready_pad_s[NUM_REQ-1:0];
  assign bus.o_tx_data   = tx_data_r;
  assign bus.o_tx_start  = tx_start_r;
  assign bus.o_grant_id  = grant_id_r;
  assign bus.o_busy      = busy_r;
  assign bus.o_timeout   = timeout_r;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: a table of frames on a 4-requester/16-gap
// instance plus hand sequences for watchdog, mid-frame reset and a 2-requester no-gap instance.
module tb_uart_tx_arbiter;

  localparam int GAP_A = 16;
  localparam int TO_A  = 4096;
  localparam int TO_B  = 8;

  logic clk = 1'b0;
  logic rst;
  int   n_pass  = 0;
  int   n_total = 0;

  always #5 clk = ~clk;

  uart_tx_arbiter_if #(.NUM_REQ(4)) bus_a ();
  uart_tx_arbiter_if #(.NUM_REQ(2)) bus_b ();

  uart_tx_arbiter #(.NUM_REQ(4), .GAP_CYCLES(GAP_A), .TIMEOUT_CYCLES(TO_A)) dut_a (
    .i_clk(clk), .i_reset(rst), .bus(bus_a)
  );
  uart_tx_arbiter #(.NUM_REQ(2), .GAP_CYCLES(0), .TIMEOUT_CYCLES(TO_B)) dut_b (
    .i_clk(clk), .i_reset(rst), .bus(bus_b)
  );

  typedef struct {
    logic [3:0]  valid;
    logic [31:0] data;
    int          busy_len;
    logic [2:0]  exp_grant;
    logic [7:0]  exp_byte;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // One full frame: request, accept, transmitter busy for busy_len cycles, gap.
  task automatic run_vec(input int idx, input vec_t v);
    int cnt;
    logic [3:0] one_hot;
    one_hot = 4'b0001 << v.exp_grant;
    @(posedge clk); #1;
    bus_a.i_req_valid = v.valid;
    bus_a.i_req_data  = v.data;
    @(negedge clk);
    check($sformatf("v%0d_ready", idx), 32'(bus_a.o_req_ready), 32'(one_hot));
    @(posedge clk); #1;
    bus_a.i_req_valid = 4'b0000;
    bus_a.i_req_data  = ~v.data;
    @(negedge clk);
    check($sformatf("v%0d_start", idx), 32'(bus_a.o_tx_start), 32'd1);
    check($sformatf("v%0d_tx_data", idx), 32'(bus_a.o_tx_data), 32'(v.exp_byte));
    check($sformatf("v%0d_grant_id", idx), 32'(bus_a.o_grant_id), 32'(v.exp_grant));
    check($sformatf("v%0d_busy", idx), 32'(bus_a.o_busy), 32'd1);
    @(posedge clk); #1;
    bus_a.i_tx_busy = 1'b1;
    @(negedge clk);
    check($sformatf("v%0d_start_end", idx), 32'(bus_a.o_tx_start), 32'd0);
    check($sformatf("v%0d_ready_off", idx), 32'(bus_a.o_req_ready), 32'd0);
    repeat (v.busy_len) @(posedge clk);
    #1;
    bus_a.i_tx_busy = 1'b0;
    cnt = 0;
    @(negedge clk);
    while (bus_a.o_busy && cnt < 200) begin
      cnt++;
      @(negedge clk);
    end
    check($sformatf("v%0d_gap_len", idx), 32'(cnt), 32'(GAP_A + 1));
    check($sformatf("v%0d_data_hold", idx), 32'(bus_a.o_tx_data), 32'(v.exp_byte));
  endtask

  // Count negedges from the current one until o_timeout is seen on instance A.
  task automatic wait_timeout_a(output int k);
    k = 0;
    while (!bus_a.o_timeout && k < TO_A + 100) begin
      @(negedge clk);
      k++;
    end
  endtask

  // From the timeout cycle, confirm a one-cycle pulse and a full gap before IDLE.
  task automatic check_after_timeout_a(input string tag);
    int cnt;
    @(negedge clk);
    check({tag, "_pulse_end"}, 32'(bus_a.o_timeout), 32'd0);
    cnt = 1;
    while (bus_a.o_busy && cnt < 100) begin
      cnt++;
      @(negedge clk);
    end
    check({tag, "_gap_len"}, 32'(cnt), 32'(GAP_A));
  endtask

  initial begin
    int k;

    vecs[0] = '{4'b0100, 32'h00A50000, 160, 3'd2, 8'hA5};
    vecs[1] = '{4'b1000, 32'h5A000000, 4,   3'd3, 8'h5A};
    vecs[2] = '{4'b1111, 32'h13121110, 3,   3'd0, 8'h10};
    vecs[3] = '{4'b1111, 32'h13121110, 3,   3'd1, 8'h11};
    vecs[4] = '{4'b1111, 32'h13121110, 3,   3'd2, 8'h12};
    vecs[5] = '{4'b1111, 32'h13121110, 3,   3'd3, 8'h13};
    vecs[6] = '{4'b1111, 32'h13121110, 3,   3'd0, 8'h10};
    vecs[7] = '{4'b0011, 32'h0000C33C, 5,   3'd1, 8'hC3};
    vecs[8] = '{4'b1001, 32'h7E0000E7, 2,   3'd3, 8'h7E};
    vecs[9] = '{4'b0110, 32'h00996600, 1,   3'd1, 8'h66};

    rst = 1'b1;
    bus_a.i_req_valid = 4'hF;
    bus_a.i_req_data  = 32'h0;
    bus_a.i_tx_busy   = 1'b0;
    bus_b.i_req_valid = 2'b11;
    bus_b.i_req_data  = 16'h0;
    bus_b.i_tx_busy   = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_ready", 32'(bus_a.o_req_ready), 32'd0);
    check("rst_ready_b", 32'(bus_b.o_req_ready), 32'd0);
    check("rst_tx_data", 32'(bus_a.o_tx_data), 32'h00);
    check("rst_start", 32'(bus_a.o_tx_start), 32'd0);
    check("rst_grant", 32'(bus_a.o_grant_id), 32'd0);
    check("rst_busy", 32'(bus_a.o_busy), 32'd0);
    check("rst_timeout", 32'(bus_a.o_timeout), 32'd0);
    bus_a.i_req_valid = 4'h0;
    bus_b.i_req_valid = 2'b00;
    @(posedge clk); #1;
    rst = 1'b0;

    for (int i = 0; i < 10; i++) run_vec(i, vecs[i]);

    // Watchdog while waiting for busy to rise.
    @(posedge clk); #1;
    bus_a.i_req_valid = 4'b0001;
    bus_a.i_req_data  = 32'h000000EE;
    @(posedge clk); #1;
    bus_a.i_req_valid = 4'b0000;
    @(negedge clk);
    check("wdb_grant", 32'(bus_a.o_grant_id), 32'd0);
    @(negedge clk);
    wait_timeout_a(k);
    check("wdb_timeout_at", 32'(k), 32'(TO_A));
    check_after_timeout_a("wdb");

    // Watchdog while waiting for busy to fall.
    @(posedge clk); #1;
    bus_a.i_req_valid = 4'b0010;
    bus_a.i_req_data  = 32'h0000DD00;
    @(posedge clk); #1;
    bus_a.i_req_valid = 4'b0000;
    @(posedge clk); #1;
    bus_a.i_tx_busy = 1'b1;
    @(negedge clk);
    @(negedge clk);
    wait_timeout_a(k);
    check("wdd_timeout_at", 32'(k), 32'(TO_A));
    check_after_timeout_a("wdd");
    check("wdd_data", 32'(bus_a.o_tx_data), 32'hDD);
    bus_a.i_tx_busy = 1'b0;

    // Reset during WAIT_DONE, then priority back at requester 0; a withdrawn request leaves no trace.
    @(posedge clk); #1;
    bus_a.i_req_valid = 4'b0100;
    bus_a.i_req_data  = 32'h00550000;
    @(posedge clk); #1;
    bus_a.i_req_valid = 4'hF;
    @(posedge clk); #1;
    bus_a.i_tx_busy = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("mid_grant", 32'(bus_a.o_grant_id), 32'd2);
    check("mid_data", 32'(bus_a.o_tx_data), 32'h55);
    check("mid_busy", 32'(bus_a.o_busy), 32'd1);
    #1;
    rst = 1'b1;
    #1;
    check("mrst_tx_data", 32'(bus_a.o_tx_data), 32'h00);
    check("mrst_grant", 32'(bus_a.o_grant_id), 32'd0);
    check("mrst_busy", 32'(bus_a.o_busy), 32'd0);
    check("mrst_ready", 32'(bus_a.o_req_ready), 32'd0);
    check("mrst_start", 32'(bus_a.o_tx_start), 32'd0);
    bus_a.i_tx_busy = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_ready", 32'(bus_a.o_req_ready), 32'b0001);
    bus_a.i_req_valid = 4'h0;
    @(negedge clk);
    check("withdraw_busy", 32'(bus_a.o_busy), 32'd0);
    check("withdraw_start", 32'(bus_a.o_tx_start), 32'd0);
    check("withdraw_data", 32'(bus_a.o_tx_data), 32'h00);

    // Two requesters, no gap: ready returns the cycle after the busy fall is sampled.
    @(posedge clk); #1;
    bus_b.i_req_valid = 2'b11;
    bus_b.i_req_data  = 16'hB2B1;
    @(negedge clk);
    check("b_ready0", 32'(bus_b.o_req_ready), 32'b01);
    @(posedge clk); #1;
    @(negedge clk);
    check("b_start0", 32'(bus_b.o_tx_start), 32'd1);
    check("b_data0", 32'(bus_b.o_tx_data), 32'hB1);
    @(posedge clk); #1;
    bus_b.i_tx_busy = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    bus_b.i_tx_busy = 1'b0;
    @(negedge clk);
    check("b_ready_pre_fall", 32'(bus_b.o_req_ready), 32'b00);
    @(negedge clk);
    check("b_ready_after_fall", 32'(bus_b.o_req_ready), 32'b10);
    @(posedge clk); #1;
    @(negedge clk);
    check("b_grant1", 32'(bus_b.o_grant_id), 32'd1);
    check("b_data1", 32'(bus_b.o_tx_data), 32'hB2);
    @(negedge clk);
    k = 0;
    while (!bus_b.o_timeout && k < TO_B + 50) begin
      @(negedge clk);
      k++;
    end
    check("b_timeout_at", 32'(k), 32'(TO_B));
    check("b_timeout_idle", 32'(bus_b.o_busy), 32'd0);
    check("b_timeout_ready", 32'(bus_b.o_req_ready), 32'b01);
    bus_b.i_req_valid = 2'b00;
    @(negedge clk);
    check("b_timeout_pulse_end", 32'(bus_b.o_timeout), 32'd0);
    check("b_no_accept", 32'(bus_b.o_tx_start), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
